tri_bus_arbiter: RTL

//  Two-requester arbiter directly upstream of the tri-state bus mux. Produces
//  the SEL signal for the mux's bufif1/bufif0 select input, a BUS_EN gate for
//  the drivers, and per-requester grants.
//  - Round-robin between the two requesters.
//  - Bounded tenure per owner.
//  - Mandatory dead (turnaround) cycles between owners, so both drivers never

---
 rtl/tri_bus_arbiter.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/tri_bus_arbiter.sv
// tri_bus_arbiter
//   Two-requester round-robin arbiter that sits in front of the tri-state bus
//   mux. It drives the mux select (sel), a driver enable (bus_en) and the
//   per-requester grants.
//   Guarantees:
//   - Tenure is bounded while the other requester waits.
//   - At least TURN_CYC dead cycles separate two owners, so two drivers are
//     never on the shared net in the same cycle.
//   All outputs are registered.
//
//   Optional feature macro: TRI_ARB_PARK_EN (bus parking).
//   When it is defined, an owner that releases while nobody else is asking
//   keeps the bus. When it is undefined, no parking logic exists.
//
//   state | meaning
//   ------+---------------------------------------------------------------
//   IDLE  | bus released, nobody granted; arbitrate every edge
//   OWN0  | requester 0 owns the bus (gnt0=1, sel=1, bus_en=1)
//   OWN1  | requester 1 owns the bus (gnt1=1, sel=0, bus_en=1)
//   TURN  | turnaround: bus released, sel frozen; arbitrate on final cycle

module tri_bus_arbiter #(
  parameter int TURN_CYC = 1,
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req0,
  input  logic req1,
  output logic gnt0,
  output logic gnt1,
  output logic sel,
  output logic bus_en
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2,
    TURN = 2'd3
  } state_t;

  // Turnaround is a down-counter loaded on entry; terminal count 0 marks
  // the final dead cycle.
  localparam logic [CNT_W-1:0] TURN_LOAD    = CNT_W'(TURN_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'((MAX_HOLD == 0) ? 0 : MAX_HOLD - 1);
  localparam bit               HOLD_LIMITED = (MAX_HOLD != 0);

  state_t           state;
  state_t           state_d;
  logic [CNT_W-1:0] hold_cnt;
  logic [CNT_W-1:0] hold_cnt_d;
  logic [CNT_W-1:0] turn_cnt;
  logic [CNT_W-1:0] turn_cnt_d;
  logic             last_owner;    // 0 = requester 0 owned last, 1 = requester 1
  logic             last_owner_d;
  logic             gnt0_d;
  logic             gnt1_d;
  logic             sel_d;
  logic             bus_en_d;

`ifdef TRI_ARB_PARK_EN
  logic             parked;
  logic             parked_d;
`endif

  logic             req_any;
  logic             pick1;
  logic             own_req;
  logic             oth_req;
  logic             hold_expired;
  logic [CNT_W-1:0] hold_inc;
  logic             do_arb;

  // Arbitration helpers and counter arithmetic shared by several states.
  always_comb begin
    req_any      = req0 | req1;
    // On a tie, the requester that did not own the bus last wins.
    pick1        = req1 & (~req0 | ~last_owner);
    own_req      = (state == OWN1) ? req1 : req0;
    oth_req      = (state == OWN1) ? req0 : req1;
    // ">=" rather than "==": the counter saturates while nobody waits, so
    // a requester arriving late must still be able to preempt.
    hold_expired = HOLD_LIMITED && (hold_cnt >= HOLD_LAST);
    hold_inc     = (hold_cnt == {CNT_W{1'b1}}) ? hold_cnt : hold_cnt + CNT_W'(1);
  end

  // Next-state, counter and registered-output logic.
  always_comb begin
    state_d      = state;
    hold_cnt_d   = hold_cnt;
    turn_cnt_d   = turn_cnt;
    last_owner_d = last_owner;
    do_arb       = 1'b0;
`ifdef TRI_ARB_PARK_EN
    parked_d     = parked;
`endif

    case (state)
      IDLE: begin
        do_arb = 1'b1;
      end

      OWN0, OWN1: begin
`ifdef TRI_ARB_PARK_EN
        if (!own_req) begin
          if (oth_req) begin
            state_d    = TURN;
            turn_cnt_d = TURN_LOAD;
            parked_d   = 1'b0;
          end else begin
            // Nobody else wants the bus: keep it driven and freeze the count.
            parked_d = 1'b1;
          end
        end else if (parked) begin
          // Owner came back while parked: same tenure, fresh hold count.
          parked_d   = 1'b0;
          hold_cnt_d = '0;
        end else if (oth_req && hold_expired) begin
          state_d    = TURN;
          turn_cnt_d = TURN_LOAD;
        end else begin
          hold_cnt_d = hold_inc;
        end
`else
        if (!own_req || (oth_req && hold_expired)) begin
          state_d    = TURN;
          turn_cnt_d = TURN_LOAD;
        end else begin
          hold_cnt_d = hold_inc;
        end
`endif
      end

      TURN: begin
        // Requests are ignored until the final dead cycle.
        if (turn_cnt == '0) begin
          do_arb = 1'b1;
        end else begin
          turn_cnt_d = turn_cnt - CNT_W'(1);
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase

    // The final TURN cycle arbitrates like IDLE, so no extra idle cycle is
    // inserted between owners.
    if (do_arb) begin
      if (req_any) begin
        state_d      = pick1 ? OWN1 : OWN0;
        hold_cnt_d   = '0;
        last_owner_d = pick1;
`ifdef TRI_ARB_PARK_EN
        parked_d     = 1'b0;
`endif
      end else begin
        state_d = IDLE;
      end
    end

    gnt0_d   = (state_d == OWN0);
    gnt1_d   = (state_d == OWN1);
    bus_en_d = gnt0_d | gnt1_d;
    // sel moves only on a grant edge; it is frozen while the bus is released.
    case (state_d)
      OWN0:    sel_d = 1'b1;
      OWN1:    sel_d = 1'b0;
      default: sel_d = sel;
    endcase
  end

  // State, counters, pointer and registered outputs; async clear on reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      hold_cnt   <= '0;
      turn_cnt   <= '0;
      last_owner <= 1'b1;
      gnt0       <= 1'b0;
      gnt1       <= 1'b0;
      sel        <= 1'b0;
      bus_en     <= 1'b0;
`ifdef TRI_ARB_PARK_EN
      parked     <= 1'b0;
`endif
    end else begin
      state      <= state_d;
      hold_cnt   <= hold_cnt_d;
      turn_cnt   <= turn_cnt_d;
      last_owner <= last_owner_d;
      gnt0       <= gnt0_d;
      gnt1       <= gnt1_d;
      sel        <= sel_d;
      bus_en     <= bus_en_d;
`ifdef TRI_ARB_PARK_EN
      parked     <= parked_d;
`endif
    end
  end

endmodule
